// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared MMIO map and STATUS layout for dmem_mmio
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    // Base match covers addr[31:4]; anything else in the MMIO half is unmapped.
    localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_CYCLE  = 2'd1,
        REG_TXDATA = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_COUNT_W   = 5;
    localparam int STAT_OVF       = 7;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// rtl/dmem_mmio_tx_fifo.sv - TX FIFO with registered head and push-while-full-and-popping
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       ready,
    output logic [WIDTH-1:0]           data,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;
    logic             accept;

    assign valid  = (count != '0);
    assign empty  = !valid;
    assign full   = (count == CW'(DEPTH));
    assign data   = mem[rd_ptr];
    assign pop    = valid && ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign accept = push && (!full || pop);
    assign drop   = push && !accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - word RAM plus LED, cycle counter and TX FIFO MMIO registers
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] leds,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_sel;
    logic          mmio_hit;
    mmio_reg_e     reg_sel;
    logic          wr_led;
    logic          wr_cycle;
    logic          wr_tx;
    logic          wr_status;
    logic [31:0]   cycle;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    assign ram_idx   = addr[AW+1:2];
    assign ram_sel   = !addr[31];
    assign mmio_hit  = ((addr & MMIO_MASK) == MMIO_BASE);
    assign reg_sel   = mmio_reg_e'(addr[3:2]);
    assign wr_led    = memwrite && mmio_hit && (reg_sel == REG_LED);
    assign wr_cycle  = memwrite && mmio_hit && (reg_sel == REG_CYCLE);
    assign wr_tx     = memwrite && mmio_hit && (reg_sel == REG_TXDATA);
    assign wr_status = memwrite && mmio_hit && (reg_sel == REG_STATUS);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_tx),
        .push_data (writedata),
        .ready     (tx_ready),
        .data      (tx_data),
        .valid     (tx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_comb begin
        status                                     = '0;
        status[STAT_FULL]                          = fifo_full;
        status[STAT_EMPTY]                         = fifo_empty;
        status[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(fifo_count);
        status[STAT_OVF]                           = overflow;
    end

    always_comb begin
        readdata = '0;
        if (ram_sel) begin
            readdata = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_LED:    readdata = leds;
                REG_CYCLE:  readdata = cycle;
                REG_STATUS: readdata = status;
                default:    readdata = '0;
            endcase
        end
    end

    // RAM is not cleared, but a store landing during reset must not stick.
    always_ff @(posedge clk) begin
        if (memwrite && ram_sel && !reset) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds     <= '0;
            cycle    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_led) begin
                leds <= writedata;
            end
            cycle <= wr_cycle ? writedata : cycle + 32'd1;
            if (wr_status) begin
                overflow <= 1'b0;
            end else if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed and random checks of dmem_mmio against a queue-based model
module tb_dmem_mmio;
    localparam int DW = 64;
    localparam int FD = 4;
    localparam int IW = $clog2(DW);

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic [31:0] readdata;
    logic [31:0] leds;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .leds      (leds),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram_m [DW];
    bit          known [DW];
    logic [31:0] led_m;
    logic [31:0] cyc_m;
    logic [31:0] q [$];
    bit          ovf_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit ok);
        logic [IW-1:0] idx;
        ok = 1'b1;
        idx = a[IW+1:2];
        if (!a[31]) begin
            ok = known[idx];
            return ram_m[idx];
        end
        if (a[30:4] != 27'd0) return 32'd0;
        case (a[3:2])
            2'd0:    return led_m;
            2'd1:    return cyc_m;
            2'd2:    return 32'd0;
            default: return {24'd0, ovf_m, 5'(q.size()), q.size() == 0, q.size() == FD};
        endcase
    endfunction

    task automatic check_outputs();
        logic [31:0] exp;
        bit ok;
        exp = model_read(addr, ok);
        if (ok) check_eq("readdata", readdata, exp);
        check_eq("leds", leds, led_m);
        check_eq("tx_valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) check_eq("tx_data", tx_data, q[0]);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
        @(negedge clk);
        reset = 1'b0;
        addr = a;
        writedata = wd;
        memwrite = we;
        tx_ready = rdy;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        bit pop;
        bit mm;
        bit full_before;
        logic [IW-1:0] idx;
        @(posedge clk);
        pop = (q.size() != 0) && tx_ready;
        full_before = (q.size() == FD);
        mm = addr[31] && (addr[30:4] == 27'd0);
        idx = addr[IW+1:2];
        if (pop) void'(q.pop_front());
        if (memwrite && !addr[31]) begin
            ram_m[idx] = writedata;
            known[idx] = 1'b1;
        end
        if (memwrite && mm) begin
            case (addr[3:2])
                2'd0: led_m = writedata;
                2'd2: begin
                    if (!full_before || pop) q.push_back(writedata);
                    else ovf_m = 1'b1;
                end
                2'd3: ovf_m = 1'b0;
                default: ;
            endcase
        end
        cyc_m = (memwrite && mm && addr[3:2] == 2'd1) ? writedata : cyc_m + 32'd1;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
        drive(a, wd, we, rdy);
        tick();
    endtask

    task automatic do_reset(input logic [31:0] a, input logic [31:0] wd, input logic we);
        logic [31:0] exp;
        bit ok;
        @(negedge clk);
        addr = a;
        writedata = wd;
        memwrite = we;
        tx_ready = 1'b0;
        reset = 1'b1;
        led_m = '0;
        cyc_m = '0;
        ovf_m = 1'b0;
        q.delete();
        #1;
        check_eq("rst_leds", leds, 32'd0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        exp = model_read(a, ok);
        if (ok) check_eq("rst_readdata", readdata, exp);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] exp4 [4];
        logic [31:0] a;
        int r;
        for (int i = 0; i < DW; i++) known[i] = 1'b0;

        do_reset(A_STATUS, 32'd0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
            check_eq("cycle_seq", readdata, 32'(i));
            tick();
        end
        step(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
        exp4 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        for (int i = 0; i < 3; i++) begin
            drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
            check_eq("cycle_wrap", readdata, exp4[i]);
            tick();
        end

        for (int i = 0; i < DW; i++) step(32'(i * 4), $urandom(), 1'b1, 1'b0);

        step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(32'h0000_0010, 32'd0, 1'b0, 1'b0);
        check_eq("ram_rd", readdata, 32'hDEAD_BEEF);
        tick();
        drive(32'h0000_0110, 32'd0, 1'b0, 1'b0);
        check_eq("ram_alias", readdata, 32'hDEAD_BEEF);
        tick();
        drive(32'h0000_0010, 32'h1111_2222, 1'b1, 1'b0);
        check_eq("ram_rd_old", readdata, 32'hDEAD_BEEF);
        tick();

        for (int v = 1; v <= 5; v++) step(A_TX, 32'(v), 1'b1, 1'b0);
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        check_eq("status_ovf", readdata, 32'h0000_0091);
        tick();
        for (int v = 1; v <= 4; v++) begin
            drive(A_STATUS, 32'd0, 1'b0, 1'b1);
            check_eq("drain", tx_data, 32'(v));
            tick();
        end
        drive(A_STATUS, 32'd0, 1'b0, 1'b1);
        check_eq("drained_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        step(A_STATUS, 32'd0, 1'b1, 1'b0);
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        check_eq("ovf_clear", readdata, 32'h0000_0002);
        tick();

        for (int v = 10; v <= 13; v++) step(A_TX, 32'(v), 1'b1, 1'b0);
        step(A_TX, 32'h0000_00A5, 1'b1, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        check_eq("full_pushpop", readdata, 32'h0000_0011);
        tick();
        exp4 = '{32'd11, 32'd12, 32'd13, 32'hA5};
        for (int i = 0; i < 4; i++) begin
            drive(A_STATUS, 32'd0, 1'b0, 1'b1);
            check_eq("order", tx_data, exp4[i]);
            tick();
        end

        step(A_LED, 32'h0000_00FF, 1'b1, 1'b0);
        step(A_TX, 32'd7, 1'b1, 1'b0);
        step(A_TX, 32'd8, 1'b1, 1'b0);
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        check_eq("status_two", readdata, 32'h0000_0008);
        tick();
        do_reset(A_STATUS, 32'd0, 1'b0);
        check_eq("rst_status", readdata, 32'h0000_0002);
        do_reset(32'h0000_0014, 32'hBAD0_BAD0, 1'b1);
        drive(32'h0000_0014, 32'd0, 1'b0, 1'b0);
        check_eq("rst_store_blocked", {31'd0, readdata == 32'hBAD0_BAD0}, 32'd0);
        tick();

        step(A_LED, 32'h0000_0033, 1'b1, 1'b0);
        drive(32'h8000_0010, 32'd0, 1'b0, 1'b0);
        check_eq("unmapped_rd", readdata, 32'd0);
        tick();
        step(32'h8000_0010, 32'h1234_5678, 1'b1, 1'b0);
        drive(A_LED, 32'd0, 1'b0, 1'b0);
        check_eq("unmapped_wr", readdata, 32'h0000_0033);
        tick();

        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) a = $urandom() & 32'h7FFF_FFFF;
            else if (r < 9) a = A_LED | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
            else a = 32'h8000_0000 | $urandom();
            if ($urandom_range(0, 249) == 0) do_reset(a, $urandom(), 1'($urandom_range(0, 1)));
            else step(a, $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit RAM words (power of two).
REQ-002 Parameter: FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  byte address from core data port.
REQ-006 writedata  input  32  store data from core.
REQ-007 memwrite  input  1  store strobe; word write when high.
REQ-008 readdata  output  32  load data, combinational from addr.
REQ-009 leds  output  32  LED register contents.
REQ-010 tx_data  output  32  head of TX FIFO.
REQ-011 tx_valid  output  1  TX FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts tx_data when high with tx_valid.

Function
REQ-013 Decode: addr[31]=0 selects RAM; addr[31]=1 selects MMIO at offset addr[3:2]; addr[1:0] ignored (word access only).
REQ-014 RAM index = addr[log2(DEPTH_WORDS)+1:2]; higher bits ignored (aliasing wrap-around).
REQ-015 RAM read combinational, zero-latency; RAM write at posedge clk when memwrite; read of same address in the write cycle returns old data.
REQ-016 MMIO 0x8000_0000 LED: R/W; write updates leds next edge.
REQ-017 MMIO 0x8000_0004 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0; write loads writedata, load overrides increment.
REQ-018 MMIO 0x8000_0008 TXDATA: write pushes writedata into FIFO; read returns 0.
REQ-019 MMIO 0x8000_000C STATUS read: bit0 full, bit1 empty, bits[6:2] count, bit7 sticky overflow, others 0; any write clears overflow.
REQ-020 MMIO addresses with addr[30:4] nonzero read 0, writes ignored.
REQ-021 Pop occurs on posedge when tx_valid && tx_ready; tx_data/tx_valid are registered/state-derived, never combinational from tx_ready.
REQ-022 Push accepted when not full, or when full and a pop occurs in the same cycle; otherwise data dropped and overflow set.
REQ-023 Simultaneous push and pop: count unchanged, order preserved; on empty, no pop occurs (tx_valid low), push accepted.
REQ-024 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-025 tx_data holds stable while tx_valid && !tx_ready.

Reset
REQ-026 On reset assertion, immediately: leds=0, counter=0, FIFO pointers/count=0, overflow=0, tx_valid=0.
REQ-027 RAM contents not reset; undefined until written.
REQ-028 Reset mid-transfer discards FIFO contents; a store coincident with reset has no effect.

Structure
REQ-029 Shared package holds MMIO base (0x8000_0000), register offsets, STATUS bit positions.
REQ-030 FIFO implemented as sub-module tx_fifo (push/pop/full/empty/count); RAM, decode, LED, counter inline.

Verification
REQ-031 Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0110 (DEPTH 64) -> both read 0xDEADBEEF.
REQ-032 After reset, read CYCLE on successive cycles -> 0,1,2...; write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0.
REQ-033 tx_ready=0, push 5 words (1..5) -> STATUS=0x0000_0091 (full, count 4, overflow); tx_ready=1 -> tx_data 1,2,3,4 then tx_valid=0; STATUS write clears bit7.
REQ-034 FIFO full, tx_ready=1, push 0xA5 in same cycle -> accepted, count stays 4, 0xA5 emerges last, no overflow.
REQ-035 Write 0x0000_00FF to LED, assert reset mid-test with 2 FIFO entries -> leds=0, tx_valid=0, STATUS=0x0000_0002 immediately.
REQ-036 Read 0x8000_0010 and write to it -> readdata=0, no state change.
